rotate_left_sequencer: RTL and testbench

Multi-cycle controller that sequences the shared rotate_left_operator datapath.
- Accepts one rotate request over a valid/ready handshake. The request carries a data word and a wide rotate amount; the amount may exceed SIZE.
- Reduces the amount modulo SIZE, then applies the rotation in bounded chunks, at most MAX_STEP bits per cycle. This limits the per-cycle rotate depth for timing.
- Returns the result and the BUSY cycle count over a second valid/ready handshake.
- Sits between a requesting pipeline stage and the rotate datapath.

---
 rtl/rotl_seq_pkg.sv | 19 +
 rtl/rotate_left_operator.sv | 28 ++
 rtl/rotate_left_sequencer.sv | 119 +++++++++++
 tb/tb_rotate_left_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotl_seq_pkg.sv
// Shared types and helpers for the rotate-left sequencer.
// State encoding plus the per-cycle step limiter.
package rotl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } rotl_seq_state_t;

    // Rotation applied this cycle: remaining amount capped at the step limit.
    function automatic int unsigned rotl_seq_min_step(
        input int unsigned rem,
        input int unsigned max_step
    );
        return (rem < max_step) ? rem : max_step;
    endfunction

endpackage

// File: rtl/rotate_left_operator.sv
// Combinational rotate-left datapath.
// Two equivalent forms: double-width shift and per-bit index wrap.
module rotate_left_operator #(
    parameter int SIZE       = 16,
    parameter int SHAMT_SIZE = 4
) (
    input  logic [SIZE-1:0]       data_i,
    input  logic [SHAMT_SIZE-1:0] shamt_i,
    output logic [SIZE-1:0]       result_by_shift_o,
    output logic [SIZE-1:0]       result_by_borders_o
);

    logic [2*SIZE-1:0] dbl;

    // Bits shifted out of the top half wrap in from the lower copy.
    assign dbl = {data_i, data_i} << shamt_i;
    assign result_by_shift_o = dbl[2*SIZE-1:SIZE];

    // Each output bit pulls from its source index, wrapping modulo SIZE.
    always_comb begin
        result_by_borders_o = '0;
        for (int i = 0; i < SIZE; i++) begin
            result_by_borders_o[i] =
                data_i[SHAMT_SIZE'(i) - shamt_i];
        end
    end

endmodule

// File: rtl/rotate_left_sequencer.sv
// Multi-cycle rotate-left controller.
// Reduces the amount mod SIZE and rotates in capped chunks per cycle.
module rotate_left_sequencer
    import rotl_seq_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int AMT_W  = 8,
    parameter int STEP_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [SIZE-1:0]          req_data_i,
    input  logic [AMT_W-1:0]         req_amt_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [SIZE-1:0]          rsp_data_o,
    output logic [$clog2(SIZE):0]    rsp_cycles_o,
    output logic                     busy_o
);

    localparam int LOG = $clog2(SIZE);
    localparam int CW  = LOG + 1;
    localparam int unsigned MAX_STEP = (2 ** STEP_W) - 1;

    rotl_seq_state_t state_q;

    logic [SIZE-1:0] data_q;
    logic [LOG-1:0]  rem_q;
    logic [CW-1:0]   cyc_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            busy_q;

    logic [LOG-1:0]  amt_red;
    logic [LOG-1:0]  step;
    logic [SIZE-1:0] rot_data;
    logic [SIZE-1:0] unused_borders;
    logic            unused_amt_hi;

    // Only the low bits of the amount matter after mod-SIZE reduction.
    assign amt_red       = req_amt_i[LOG-1:0];
    assign unused_amt_hi = ^req_amt_i[AMT_W-1:LOG];

    // Chunk applied in the current BUSY cycle.
    assign step = LOG'(rotl_seq_min_step(32'(rem_q), MAX_STEP));

    rotate_left_operator #(
        .SIZE       (SIZE),
        .SHAMT_SIZE (LOG)
    ) u_rotl (
        .data_i              (data_q),
        .shamt_i             (step),
        .result_by_shift_o   (rot_data),
        .result_by_borders_o (unused_borders)
    );

    // Control FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            cyc_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        data_q      <= req_data_i;
                        rem_q       <= amt_red;
                        cyc_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (amt_red != '0) begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    data_q <= rot_data;
                    rem_q  <= rem_q - step;
                    cyc_q  <= cyc_q + CW'(1);
                    if (rem_q == step) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign busy_o       = busy_q;
    assign rsp_data_o   = data_q;
    assign rsp_cycles_o = cyc_q;

endmodule

// File: tb/tb_rotate_left_sequencer.sv
// Self-checking bench for rotate_left_sequencer.
// Directed plan cases plus randomized traffic against a reference model.
module tb_rotate_left_sequencer;

    localparam int SIZE   = 16;
    localparam int AMT_W  = 8;
    localparam int STEP_W = 2;
    localparam int MAXS   = (2 ** STEP_W) - 1;
    localparam int LIMIT  = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [SIZE-1:0]  req_data_i;
    logic [AMT_W-1:0] req_amt_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [SIZE-1:0]  rsp_data_o;
    logic [4:0]       rsp_cycles_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    rotate_left_sequencer #(
        .SIZE   (SIZE),
        .AMT_W  (AMT_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_data_i   (req_data_i),
        .req_amt_i    (req_amt_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_cycles_o (rsp_cycles_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Reference: rotate by reducing amount, bit-by-bit index mapping.
    function automatic logic [SIZE-1:0] model_rot(
        input logic [SIZE-1:0] d, input int amt);
        logic [SIZE-1:0] r;
        int sh;
        sh = amt % SIZE;
        r = '0;
        for (int i = 0; i < SIZE; i++)
            r[(i + sh) % SIZE] = d[i];
        return r;
    endfunction

    function automatic int model_cyc(input int amt);
        return ((amt % SIZE) + MAXS - 1) / MAXS;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and wait for the response; reports observations.
    task automatic run_txn(
        input  logic [SIZE-1:0]  d,
        input  logic [AMT_W-1:0] a,
        output logic [SIZE-1:0]  got_d,
        output int               got_c,
        output int               lat,
        output int               nbusy,
        output bit               ok
    );
        req_valid_i = 1'b1;
        req_data_i  = d;
        req_amt_i   = a;
        tick();
        req_valid_i = 1'b0;
        req_data_i  = SIZE'($urandom);
        req_amt_i   = AMT_W'($urandom);
        lat   = 1;
        nbusy = 0;
        while (!rsp_valid_o && lat < LIMIT) begin
            if (busy_o) nbusy++;
            tick();
            lat++;
        end
        ok    = rsp_valid_o;
        got_d = rsp_data_o;
        got_c = int'(rsp_cycles_o);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req_valid_i = 1'b0;
        req_data_i  = '0;
        req_amt_i   = '0;
        rsp_ready_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 1", req_ready_o);
        end
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o);
        end
        checks++;
        if (rsp_data_o !== '0) begin
            errors++;
            $display("FAIL reset_rsp_data got %h want 0", rsp_data_o);
        end
        checks++;
        if (rsp_cycles_o !== '0) begin
            errors++;
            $display("FAIL reset_rsp_cycles got %0d want 0", rsp_cycles_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy_o);
        end
    endtask

    task automatic test_directed();
        logic [SIZE-1:0]  td [5] = '{16'h0008, 16'h0008, 16'h8001,
                                     16'hA5C3, 16'hA5C3};
        logic [AMT_W-1:0] ta [5] = '{8'd15, 8'd17, 8'd4, 8'd0, 8'd16};
        logic [SIZE-1:0]  te [5] = '{16'h0004, 16'h0010, 16'h0018,
                                     16'hA5C3, 16'hA5C3};
        int               tc [5] = '{5, 1, 2, 0, 0};
        logic [SIZE-1:0]  gd;
        int gc, lat, nb;
        bit ok;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_txn(td[k], ta[k], gd, gc, lat, nb, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL dir%0d_timeout no rsp_valid in %0d cycles", k, LIMIT);
            end
            checks++;
            if (gd !== te[k]) begin
                errors++;
                $display("FAIL dir%0d_data got %h want %h", k, gd, te[k]);
            end
            checks++;
            if (gc != tc[k]) begin
                errors++;
                $display("FAIL dir%0d_cycles got %0d want %0d", k, gc, tc[k]);
            end
            checks++;
            if (lat != tc[k] + 1 || nb != tc[k]) begin
                errors++;
                $display("FAIL dir%0d_latency got lat %0d busy %0d want lat %0d busy %0d",
                         k, lat, nb, tc[k] + 1, tc[k]);
            end
            tick();
            checks++;
            if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_pulse got valid %b ready %b want 0 1",
                         k, rsp_valid_o, req_ready_o);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [SIZE-1:0] gd;
        int gc, lat, nb;
        bit ok;
        rsp_ready_i = 1'b0;
        run_txn(16'h0001, 8'd1, gd, gc, lat, nb, ok);
        req_valid_i = 1'b1;
        req_data_i  = 16'h1234;
        req_amt_i   = 8'd8;
        checks++;
        if (!ok || gd !== 16'h0002 || gc != 1) begin
            errors++;
            $display("FAIL bp_first got ok %b data %h cyc %0d want 1 0002 1", ok, gd, gc);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 16'h0002 ||
                rsp_cycles_o !== 5'd1 || req_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got valid %b data %h cyc %0d ready %b want 1 0002 1 0",
                         k, rsp_valid_o, rsp_data_o, rsp_cycles_o, req_ready_o);
            end
        end
        rsp_ready_i = 1'b1;
        tick();
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got valid %b ready %b want 0 1", rsp_valid_o, req_ready_o);
        end
        run_txn(16'h1234, 8'd8, gd, gc, lat, nb, ok);
        checks++;
        if (!ok || gd !== 16'h3412 || gc != 3 || lat != 4) begin
            errors++;
            $display("FAIL bp_second got ok %b data %h cyc %0d lat %0d want 1 3412 3 4",
                     ok, gd, gc, lat);
        end
        tick();
    endtask

    task automatic test_random();
        logic [SIZE-1:0]  d, gd;
        logic [AMT_W-1:0] a;
        int gc, lat, nb, stall;
        bit ok;
        for (int n = 0; n < 40; n++) begin
            d     = SIZE'($urandom);
            a     = AMT_W'($urandom);
            stall = int'($urandom_range(0, 3));
            rsp_ready_i = (stall == 0);
            run_txn(d, a, gd, gc, lat, nb, ok);
            checks++;
            if (!ok || gd !== model_rot(d, int'(a)) || gc != model_cyc(int'(a)) ||
                lat != model_cyc(int'(a)) + 1 || nb != model_cyc(int'(a))) begin
                errors++;
                $display("FAIL rnd%0d d %h a %0d got %h cyc %0d lat %0d want %h cyc %0d",
                         n, d, a, gd, gc, lat, model_rot(d, int'(a)), model_cyc(int'(a)));
            end
            for (int s = 0; s < stall; s++) begin
                tick();
                checks++;
                if (rsp_valid_o !== 1'b1 || rsp_data_o !== gd) begin
                    errors++;
                    $display("FAIL rnd%0d_stall got valid %b data %h want 1 %h",
                             n, rsp_valid_o, rsp_data_o, gd);
                end
            end
            rsp_ready_i = 1'b1;
            tick();
            checks++;
            if (rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_drop got valid %b want 0", n, rsp_valid_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_data_i  = 16'h0008;
        req_amt_i   = 8'd15;
        tick();
        req_valid_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b want 1", busy_o);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 ||
            rsp_data_o !== '0 || busy_o !== 1'b0 || rsp_cycles_o !== '0) begin
            errors++;
            $display("FAIL mid_reset got ready %b valid %b data %h busy %b cyc %0d want 1 0 0 0 0",
                     req_ready_o, rsp_valid_o, rsp_data_o, busy_o, rsp_cycles_o);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_ghost got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
